// File: rtl/fir_pkg.sv
// Shared constants, FSM encoding and tap extraction for the FIR window MAC.
// Sum width: 3-bit taps times 16-bit coefficients over 10 taps fits in 23 bits.
package fir_pkg;

    localparam int TAP_NUM = 10;
    localparam int DATA_W  = 3;
    localparam int COEFF_W = 16;
    localparam int ACC_W   = 23;
    localparam int CNT_W   = 4;
    localparam int ADDR_W  = 4;
    localparam int PROD_W  = DATA_W + COEFF_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_MAC,
        ST_DONE
    } state_t;

    // Tap k occupies bits [3k+2:3k]; k=0 is the newest sample.
    function automatic logic signed [DATA_W-1:0] tap_slice(
        input logic [TAP_NUM*DATA_W-1:0] word,
        input logic [CNT_W-1:0]          k
    );
        return word[int'(k)*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Double-buffered coefficient store: host writes land in shadow, and the
// load strobe copies the whole shadow set into the active set used by the MAC.
module fir_coeff_bank
    import fir_pkg::*;
(
    input  logic                      iClk12M,
    input  logic                      iRst,
    input  logic                      wr,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [COEFF_W-1:0]        data,
    input  logic                      load,
    input  logic [CNT_W-1:0]          rd_idx,
    output logic signed [COEFF_W-1:0] rd_coef
);

    logic [TAP_NUM*COEFF_W-1:0] active_bus;

    generate
        for (genvar gi = 0; gi < TAP_NUM; gi++) begin : g_coef
            logic [COEFF_W-1:0] shadow_reg;
            logic [COEFF_W-1:0] active_reg;

            // Non-blocking copy uses the pre-edge shadow, so a write on the load edge waits a sample.
            always_ff @(posedge iClk12M or posedge iRst) begin
                if (iRst) begin
                    shadow_reg <= '0;
                    active_reg <= '0;
                end else begin
                    if (wr && (addr == ADDR_W'(gi)))
                        shadow_reg <= data;
                    if (load)
                        active_reg <= shadow_reg;
                end
            end

            assign active_bus[gi*COEFF_W +: COEFF_W] = active_reg;
        end
    endgenerate

    always_comb begin
        rd_coef = '0;
        if (rd_idx < CNT_W'(TAP_NUM))
            rd_coef = active_bus[int'(rd_idx)*COEFF_W +: COEFF_W];
    end

endmodule

// File: rtl/fir_tap_mac.sv
// Serial multiply-accumulate over one 10-tap window of the FIR delay line,
// one tap per clock, producing a registered signed partial sum per sample.
module fir_tap_mac
    import fir_pkg::*;
(
    input  logic                        iClk12M,
    input  logic                        iRst,
    input  logic                        iEnSample600k,
    input  logic [TAP_NUM*DATA_W-1:0]   iDelay,
    input  logic                        iCoeffWr,
    input  logic [ADDR_W-1:0]           iCoeffAddr,
    input  logic [COEFF_W-1:0]          iCoeffData,
    output logic [ACC_W-1:0]            oMac,
    output logic                        oMacValid,
    output logic                        oBusy,
    output logic                        oOverrun
);

    state_t                       state_reg, state_next;
    logic [TAP_NUM*DATA_W-1:0]    snap_reg;
    logic [CNT_W-1:0]             cnt_reg;
    logic signed [ACC_W-1:0]      acc_reg;

    logic                         capture;
    logic                         mac_en;
    logic                         done;
    logic                         overrun;

    logic signed [COEFF_W-1:0]    coef;
    logic signed [PROD_W-1:0]     tap_ext;
    logic signed [PROD_W-1:0]     coef_ext;
    logic signed [PROD_W-1:0]     prod;

    fir_coeff_bank u_coeff_bank (
        .iClk12M (iClk12M),
        .iRst    (iRst),
        .wr      (iCoeffWr),
        .addr    (iCoeffAddr),
        .data    (iCoeffData),
        .load    (capture),
        .rd_idx  (cnt_reg),
        .rd_coef (coef)
    );

    always_ff @(posedge iClk12M or posedge iRst) begin
        if (iRst)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    // A strobe outside IDLE abandons the current window and restarts capture.
    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        mac_en     = 1'b0;
        done       = 1'b0;
        overrun    = 1'b0;
        if ((state_reg != ST_IDLE) && iEnSample600k) begin
            overrun    = 1'b1;
            state_next = ST_CAPTURE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (iEnSample600k)
                        state_next = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    capture    = 1'b1;
                    state_next = ST_MAC;
                end
                ST_MAC: begin
                    mac_en = 1'b1;
                    if (cnt_reg == CNT_W'(TAP_NUM - 1))
                        state_next = ST_DONE;
                end
                ST_DONE: begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign tap_ext  = PROD_W'(tap_slice(snap_reg, cnt_reg));
    assign coef_ext = PROD_W'(coef);
    assign prod     = tap_ext * coef_ext;

    always_ff @(posedge iClk12M or posedge iRst) begin
        if (iRst) begin
            snap_reg  <= '0;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            oMac      <= '0;
            oMacValid <= 1'b0;
            oBusy     <= 1'b0;
            oOverrun  <= 1'b0;
        end else begin
            oMacValid <= done;
            oOverrun  <= overrun;
            if (capture) begin
                snap_reg <= iDelay;
                acc_reg  <= '0;
                cnt_reg  <= '0;
                oBusy    <= 1'b1;
            end
            if (mac_en) begin
                acc_reg <= acc_reg + ACC_W'(prod);
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (done) begin
                oMac  <= acc_reg;
                oBusy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_tap_mac.sv
// Directed bench for fir_tap_mac: table of coefficient/tap windows with
// hand-computed sums, plus sequences for write timing, overrun and reset.
module tb_fir_tap_mac;

    logic        iClk12M = 1'b0;
    logic        iRst;
    logic        iEnSample600k;
    logic [29:0] iDelay;
    logic        iCoeffWr;
    logic [3:0]  iCoeffAddr;
    logic [15:0] iCoeffData;
    logic [22:0] oMac;
    logic        oMacValid;
    logic        oBusy;
    logic        oOverrun;

    int applied = 0;
    int miscompares = 0;

    fir_tap_mac dut (
        .iClk12M       (iClk12M),
        .iRst          (iRst),
        .iEnSample600k (iEnSample600k),
        .iDelay        (iDelay),
        .iCoeffWr      (iCoeffWr),
        .iCoeffAddr    (iCoeffAddr),
        .iCoeffData    (iCoeffData),
        .oMac          (oMac),
        .oMacValid     (oMacValid),
        .oBusy         (oBusy),
        .oOverrun      (oOverrun)
    );

    always #5 iClk12M = ~iClk12M;

    typedef struct packed {
        logic [159:0]       coefs;
        logic [29:0]        taps;
        logic signed [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input longint act, input longint exp);
        applied++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic write_coef(input logic [3:0] addr, input logic [15:0] data);
        iCoeffWr   = 1'b1;
        iCoeffAddr = addr;
        iCoeffData = data;
        @(posedge iClk12M); #1;
        iCoeffWr   = 1'b0;
    endtask

    task automatic load_coefs(input logic [159:0] coefs);
        logic [159:0] c;
        c = coefs;
        for (int k = 0; k < 10; k++)
            write_coef(4'(k), c[k*16 +: 16]);
    endtask

    // Strobe one sample; the delay word changes on the strobe edge, as the real delay line does.
    task automatic run_sample(input string name, input logic [29:0] word, input longint exp,
                              input int wcyc, input logic [3:0] waddr, input logic [15:0] wdata);
        int lat;
        lat = 0;
        iDelay = ~word;
        iEnSample600k = 1'b1;
        @(posedge iClk12M); #1;
        iEnSample600k = 1'b0;
        iDelay = word;
        if (wcyc == 0) begin
            iCoeffWr = 1'b1; iCoeffAddr = waddr; iCoeffData = wdata;
        end
        for (int i = 1; i <= 30; i++) begin
            @(posedge iClk12M); #1;
            iCoeffWr = 1'b0;
            if (i == wcyc) begin
                iCoeffWr = 1'b1; iCoeffAddr = waddr; iCoeffData = wdata;
            end
            if (i == 1) check({name, " busy"}, oBusy, 1);
            if (oMacValid) begin
                lat = i;
                break;
            end
        end
        iCoeffWr = 1'b0;
        check({name, " latency"}, lat, 12);
        check({name, " oMac"}, longint'($signed(oMac)), exp);
        check({name, " busy_clear"}, oBusy, 0);
        $display("sample %s: oMac=%0d latency=%0d", name, $signed(oMac), lat);
        @(posedge iClk12M); #1;
        check({name, " valid_pulse"}, oMacValid, 0);
    endtask

    initial begin
        iRst = 1'b1;
        iEnSample600k = 1'b0;
        iDelay = '0;
        iCoeffWr = 1'b0;
        iCoeffAddr = '0;
        iCoeffData = '0;

        vecs[0] = '{coefs: {10{16'd1}},    taps: {10{3'b001}}, exp: 10};
        vecs[1] = '{coefs: {10{16'h7FFF}}, taps: {10{3'b100}}, exp: -1310680};
        vecs[2] = '{coefs: {10{16'h8000}}, taps: {10{3'b100}}, exp: 1310720};
        vecs[3] = '{coefs: {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0},
                    taps: {5{3'b111, 3'b001}}, exp: -5};
        vecs[4] = '{coefs: {10{16'hFFFE}}, taps: {10{3'b011}}, exp: -60};
        vecs[5] = '{coefs: {16'd1000, 144'd0}, taps: {3'b010, {9{3'b011}}}, exp: 2000};
        vecs[6] = '{coefs: {144'd0, 16'd5},    taps: {{9{3'b001}}, 3'b101}, exp: -15};

        repeat (3) @(posedge iClk12M);
        #1;
        check("reset oMac", oMac, 0);
        check("reset valid", oMacValid, 0);
        check("reset busy", oBusy, 0);
        check("reset overrun", oOverrun, 0);
        iRst = 1'b0;
        @(posedge iClk12M); #1;

        for (int v = 0; v < 7; v++) begin
            load_coefs(vecs[v].coefs);
            run_sample($sformatf("vec%0d", v), vecs[v].taps, longint'(vecs[v].exp), -1, 4'd0, 16'd0);
        end

        // Coefficient write mid-MAC, then on the capture edge: both apply from the next sample.
        load_coefs({144'd0, 16'd1});
        run_sample("wr_mid_mac", 30'd1, 1, 4, 4'd0, 16'd100);
        run_sample("wr_mid_next", 30'd1, 100, -1, 4'd0, 16'd0);
        write_coef(4'd0, 16'd1);
        run_sample("wr_capture", 30'd1, 1, 0, 4'd0, 16'd100);
        run_sample("wr_capture_next", 30'd1, 100, -1, 4'd0, 16'd0);

        // Overrun: second strobe five clocks after the first.
        load_coefs({10{16'd1}});
        iDelay = {10{3'b001}};
        iEnSample600k = 1'b1;
        @(posedge iClk12M); #1;
        iEnSample600k = 1'b0;
        repeat (4) @(posedge iClk12M);
        #1;
        iEnSample600k = 1'b1;
        @(posedge iClk12M); #1;
        iEnSample600k = 1'b0;
        check("overrun pulse", oOverrun, 1);
        begin
            int lat;
            lat = 0;
            for (int i = 1; i <= 30; i++) begin
                @(posedge iClk12M); #1;
                if (i == 1) check("overrun pulse_end", oOverrun, 0);
                if (i == 11) check("overrun oMac_held", longint'($signed(oMac)), 100);
                if (oMacValid) begin
                    lat = i;
                    break;
                end
            end
            check("overrun latency", lat, 12);
            check("overrun oMac", longint'($signed(oMac)), 10);
            $display("sample overrun: oMac=%0d latency=%0d", $signed(oMac), lat);
        end
        @(posedge iClk12M); #1;

        // Reset mid-MAC, then a write to an unused address must not reach any coefficient.
        iEnSample600k = 1'b1;
        @(posedge iClk12M); #1;
        iEnSample600k = 1'b0;
        repeat (5) @(posedge iClk12M);
        #1;
        iRst = 1'b1;
        #1;
        check("midrst oMac", oMac, 0);
        check("midrst valid", oMacValid, 0);
        check("midrst busy", oBusy, 0);
        check("midrst overrun", oOverrun, 0);
        @(posedge iClk12M); #1;
        iRst = 1'b0;
        write_coef(4'd12, 16'd77);
        begin
            int nvalid;
            nvalid = 0;
            for (int i = 0; i < 15; i++) begin
                @(posedge iClk12M); #1;
                if (oMacValid) nvalid++;
            end
            check("midrst no_valid", nvalid, 0);
        end
        run_sample("after_rst", {10{3'b001}}, 0, -1, 4'd0, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
